// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fp_pkg
// Brief    : Shared float32 field widths, constants, accumulator state encoding
//            and a leading-zero counter used by the add_sub datapath.
// Revision : 1.0 - initial release
// ============================================================================
package fp_pkg;

    localparam int FP_W   = 32;
    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int MANT_W = FRAC_W + 1;
    localparam int EXT_W  = MANT_W + 3;

    localparam logic [FP_W-1:0] FP_POS_ZERO = 32'h0000_0000;
    localparam logic [FP_W-1:0] FP_POS_INF  = 32'h7F80_0000;
    localparam logic [FP_W-1:0] FP_QNAN     = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FIRST = 3'd1,
        FETCH = 3'd2,
        ADD   = 3'd3,
        DONE  = 3'd4
    } acc_state_t;

    // Returns EXT_W when v is zero.
    function automatic logic [4:0] fp_lzc27(input logic [EXT_W-1:0] v);
        logic [4:0] n;
        logic       found;
        n     = 5'(EXT_W);
        found = 1'b0;
        for (int i = EXT_W - 1; i >= 0; i--) begin
            if (!found && v[i]) begin
                n     = 5'(EXT_W - 1 - i);
                found = 1'b1;
            end
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/add_sub.sv
`default_nettype none
// ============================================================================
// Module   : add_sub
// Brief    : Combinational float32 adder/subtractor, round-to-nearest-even,
//            subnormal inputs treated as zero, underflowing results flushed
//            to signed zero.
// Revision : 1.0 - initial release
// ============================================================================
module add_sub
    import fp_pkg::*;
(
    input  logic [FP_W-1:0] a,
    input  logic [FP_W-1:0] b,
    input  logic            add_or_sub,
    output logic [FP_W-1:0] result,
    output logic            overflow,
    output logic            underflow
);

    logic                    w_sa;
    logic                    w_sb;
    logic [EXP_W-1:0]        w_ea;
    logic [EXP_W-1:0]        w_eb;
    logic [FRAC_W-1:0]       w_fa;
    logic [FRAC_W-1:0]       w_fb;
    logic                    w_a_nan;
    logic                    w_b_nan;
    logic                    w_a_inf;
    logic                    w_b_inf;
    logic                    w_swap;
    logic                    w_sl;
    logic [EXP_W-1:0]        w_el;
    logic [EXP_W-1:0]        w_es;
    logic [MANT_W-1:0]       w_ml;
    logic [MANT_W-1:0]       w_ms;
    logic [EXP_W-1:0]        w_diff;
    logic [4:0]              w_sh;
    logic [2*EXT_W-1:0]      w_shifted;
    logic [EXT_W-1:0]        w_al;
    logic [EXT_W-1:0]        w_as;
    logic                    w_eff_sub;
    logic [EXT_W:0]          w_sum;
    logic [4:0]              w_lz;
    logic [EXT_W-1:0]        w_norm;
    logic signed [9:0]       w_exp_n;
    logic                    w_rup;
    logic [MANT_W:0]         w_rnd;
    logic signed [9:0]       w_exp_r;
    logic [FRAC_W-1:0]       w_frac_r;

    always_comb begin
        w_sa      = a[FP_W-1];
        w_sb      = b[FP_W-1] ^ add_or_sub;
        w_ea      = a[FP_W-2:FRAC_W];
        w_eb      = b[FP_W-2:FRAC_W];
        w_fa      = (w_ea == '0) ? '0 : a[FRAC_W-1:0];
        w_fb      = (w_eb == '0) ? '0 : b[FRAC_W-1:0];
        w_a_nan   = (w_ea == '1) && (a[FRAC_W-1:0] != '0);
        w_b_nan   = (w_eb == '1) && (b[FRAC_W-1:0] != '0);
        w_a_inf   = (w_ea == '1) && (a[FRAC_W-1:0] == '0);
        w_b_inf   = (w_eb == '1) && (b[FRAC_W-1:0] == '0);
        w_eff_sub = w_sa ^ w_sb;

        // Larger magnitude always goes on the left so the difference is non-negative.
        w_swap = {w_eb, w_fb} > {w_ea, w_fa};
        if (w_swap) begin
            w_sl = w_sb;
            w_el = w_eb;
            w_es = w_ea;
            w_ml = {(w_eb != '0), w_fb};
            w_ms = {(w_ea != '0), w_fa};
        end else begin
            w_sl = w_sa;
            w_el = w_ea;
            w_es = w_eb;
            w_ml = {(w_ea != '0), w_fa};
            w_ms = {(w_eb != '0), w_fb};
        end

        w_diff    = w_el - w_es;
        w_sh      = (w_diff > 8'd27) ? 5'd27 : w_diff[4:0];
        w_shifted = {w_ms, 3'b000, {EXT_W{1'b0}}} >> w_sh;
        w_as      = w_shifted[2*EXT_W-1:EXT_W];
        w_as[0]   = w_as[0] | (|w_shifted[EXT_W-1:0]);
        w_al      = {w_ml, 3'b000};

        w_sum = w_eff_sub ? ({1'b0, w_al} - {1'b0, w_as})
                          : ({1'b0, w_al} + {1'b0, w_as});

        w_lz = fp_lzc27(w_sum[EXT_W-1:0]);
        if (w_sum[EXT_W]) begin
            w_norm  = {w_sum[EXT_W:2], w_sum[1] | w_sum[0]};
            w_exp_n = $signed({2'b00, w_el}) + 10'sd1;
        end else begin
            w_norm  = w_sum[EXT_W-1:0] << w_lz;
            w_exp_n = $signed({2'b00, w_el}) - $signed({5'd0, w_lz});
        end

        w_rup = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
        w_rnd = {1'b0, w_norm[EXT_W-1:3]} + {{MANT_W{1'b0}}, w_rup};
        if (w_rnd[MANT_W]) begin
            w_exp_r  = w_exp_n + 10'sd1;
            w_frac_r = w_rnd[MANT_W-1:1];
        end else begin
            w_exp_r  = w_exp_n;
            w_frac_r = w_rnd[FRAC_W-1:0];
        end

        result    = FP_POS_ZERO;
        overflow  = 1'b0;
        underflow = 1'b0;
        if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && w_eff_sub)) begin
            result = FP_QNAN;
        end else if (w_a_inf) begin
            result = {w_sa, FP_POS_INF[FP_W-2:0]};
        end else if (w_b_inf) begin
            result = {w_sb, FP_POS_INF[FP_W-2:0]};
        end else if (w_sum == '0) begin
            result = {w_sa & w_sb, {(FP_W-1){1'b0}}};
        end else if (w_exp_r >= 10'sd255) begin
            result   = {w_sl, FP_POS_INF[FP_W-2:0]};
            overflow = 1'b1;
        end else if (w_exp_r <= 10'sd0) begin
            result    = {w_sl, {(FP_W-1){1'b0}}};
            underflow = 1'b1;
        end else begin
            result = {w_sl, w_exp_r[EXP_W-1:0], w_frac_r};
        end
    end

endmodule
`default_nettype wire

// File: rtl/fp_accum_seq.sv
`default_nettype none
// ============================================================================
// Module   : fp_accum_seq
// Brief    : Sequential float32 accumulator driving one add_sub instance.
//            Optional FP_ACCUM_EARLY_STOP_EN: stop at the first overflowing step.
// Revision : 1.0 - initial release
// ============================================================================
module fp_accum_seq
    import fp_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             sub_mode,
    input  logic             in_valid,
    input  logic [FP_W-1:0]  in_data,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [FP_W-1:0]  out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             overflag,
    output logic             underflag,
    output logic             busy
);

    localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

    acc_state_t        r_state;
    logic [FP_W-1:0]   r_acc;
    logic [FP_W-1:0]   r_op;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  r_len;
    logic              r_sub;
    logic              r_over;
    logic              r_under;
    logic              r_in_ready;
    logic              r_out_valid;
    logic              r_busy;

    logic [FP_W-1:0]   w_result;
    logic              w_ovf;
    logic              w_unf;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic              w_last;

    add_sub u_add_sub (
        .a          (r_acc),
        .b          (r_op),
        .add_or_sub (r_sub),
        .result     (w_result),
        .overflow   (w_ovf),
        .underflow  (w_unf)
    );

    assign w_cnt_inc = r_cnt + c_one;
`ifdef FP_ACCUM_EARLY_STOP_EN
    assign w_last = (w_cnt_inc == r_len) || w_ovf;
`else
    assign w_last = (w_cnt_inc == r_len);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_acc       <= FP_POS_ZERO;
            r_op        <= FP_POS_ZERO;
            r_cnt       <= '0;
            r_len       <= '0;
            r_sub       <= 1'b0;
            r_over      <= 1'b0;
            r_under     <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_len   <= len;
                        r_sub   <= sub_mode;
                        r_acc   <= FP_POS_ZERO;
                        r_cnt   <= '0;
                        r_over  <= 1'b0;
                        r_under <= 1'b0;
                        r_busy  <= 1'b1;
                        if (len == '0) begin
                            r_state     <= DONE;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state    <= FIRST;
                            r_in_ready <= 1'b1;
                        end
                    end
                end
                FIRST: begin
                    // First operand seeds the accumulator as-is, even in subtract mode.
                    if (in_valid && r_in_ready) begin
                        r_acc <= in_data;
                        r_cnt <= c_one;
                        if (r_len == c_one) begin
                            r_state     <= DONE;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    if (in_valid && r_in_ready) begin
                        r_op       <= in_data;
                        r_state    <= ADD;
                        r_in_ready <= 1'b0;
                    end
                end
                ADD: begin
                    r_acc   <= w_result;
                    r_over  <= r_over | w_ovf;
                    r_under <= r_under | w_unf;
                    r_cnt   <= w_cnt_inc;
                    if (w_last) begin
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_state    <= FETCH;
                        r_in_ready <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_sum   = r_acc;
    assign out_count = r_cnt;
    assign overflag  = r_over;
    assign underflag = r_under;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_fp_accum_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_accum_seq
// Brief    : Scoreboard bench for fp_accum_seq with directed float32 vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_accum_seq;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] len;
    logic             sub_mode;
    logic             in_valid;
    logic [31:0]      in_data;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_sum;
    logic [CNT_W-1:0] out_count;
    logic             overflag;
    logic             underflag;
    logic             busy;

    typedef struct packed {
        logic [31:0]      sum;
        logic [CNT_W-1:0] count;
        logic             over;
        logic             under;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;
    int   hs_cnt = 0;
    int   hs0;

    always #5 clk = ~clk;

    fp_accum_seq #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .sub_mode  (sub_mode),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .overflag  (overflag),
        .underflag (underflag),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] s, input int c, input logic o, input logic u);
        exp_t e;
        e.sum   = s;
        e.count = CNT_W'(c);
        e.over  = o;
        e.under = u;
        return e;
    endfunction

    function automatic logic [3:0][31:0] pack4(input logic [31:0] a0, a1, a2, a3);
        return {a3, a2, a1, a0};
    endfunction

    // Monitor: counts input handshakes and scores every accepted result.
    always @(negedge clk) begin
        if (!rst && in_valid && in_ready) hs_cnt++;
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got sum %0h with empty queue", out_sum);
            end else begin
                mon_e = sb_q.pop_front();
                check("out_sum",   out_sum,              mon_e.sum);
                check("out_count", 32'(out_count),       32'(mon_e.count));
                check("overflag",  32'(overflag),        32'(mon_e.over));
                check("underflag", 32'(underflag),       32'(mon_e.under));
            end
        end
    end

    task automatic start_run(input logic [CNT_W-1:0] n, input logic sm);
        @(posedge clk); #1;
        start = 1'b1; len = n; sub_mode = sm;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic feed(input logic [31:0] d, input int gap);
        bit ok;
        ok = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        in_valid = 1'b1;
        in_data  = d;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk); #1;
                ok = 1'b1;
            end
        end
        in_valid = 1'b0;
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL feed_timeout: got no handshake expected handshake for %0h", d);
        end
    endtask

    task automatic wait_done();
        for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(posedge clk);
        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL result_timeout: got %0d pending expected 0", sb_q.size());
            sb_q.delete();
        end
        #1;
    endtask

    task automatic run(input logic [CNT_W-1:0] n, input logic sm,
                       input logic [3:0][31:0] d, input int gap, input exp_t e);
        sb_q.push_back(e);
        start_run(n, sm);
        for (int i = 0; i < int'(n); i++) feed(d[i], gap);
        wait_done();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; len = '0; sub_mode = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_out_sum",   out_sum,        32'd0);
        check("rst_count",     32'(out_count), 32'd0);
        check("rst_flags",     32'({overflag, underflag}), 32'd0);

        // 1 + 2 + 0.5 = 3.5
        run(3, 1'b0, pack4(32'h3F800000, 32'h40000000, 32'h3F000000, 0), 0,
            mk(32'h40600000, 3, 1'b0, 1'b0));

        // max + max overflows to +inf
`ifdef FP_ACCUM_EARLY_STOP_EN
        sb_q.push_back(mk(32'h7F800000, 2, 1'b1, 1'b0));
        hs0 = hs_cnt;
        start_run(4, 1'b0);
        feed(32'h7F7FFFFF, 0);
        feed(32'h7F7FFFFF, 0);
        wait_done();
        check("early_stop_hs", 32'(hs_cnt - hs0), 32'd2);
`else
        run(2, 1'b0, pack4(32'h7F7FFFFF, 32'h7F7FFFFF, 0, 0), 0,
            mk(32'h7F800000, 2, 1'b1, 1'b0));
`endif

        // 5 - 1 - 1.5 = 2.5, flags cleared from the previous run
        run(3, 1'b1, pack4(32'h40A00000, 32'h3F800000, 32'h3FC00000, 0), 0,
            mk(32'h40200000, 3, 1'b0, 1'b0));

        // 1.5 - 1.5 = +0
        run(2, 1'b1, pack4(32'h3FC00000, 32'h3FC00000, 0, 0), 0,
            mk(32'h00000000, 2, 1'b0, 1'b0));

        // Data offered in IDLE is never accepted
        hs0 = hs_cnt;
        in_valid = 1'b1; in_data = 32'h3F800000;
        repeat (4) @(negedge clk);
        check("idle_in_ready", 32'(in_ready), 32'd0);
        check("idle_no_hs", 32'(hs_cnt - hs0), 32'd0);
        in_valid = 1'b0;

        // len = 0 completes the cycle after start with no input handshake
        hs0 = hs_cnt;
        sb_q.push_back(mk(32'h00000000, 0, 1'b0, 1'b0));
        start_run(0, 1'b0);
        @(negedge clk);
        check("len0_out_valid", 32'(out_valid), 32'd1);
        check("len0_busy", 32'(busy), 32'd1);
        wait_done();
        check("len0_no_hs", 32'(hs_cnt - hs0), 32'd0);

        // Backpressure: result held stable while out_ready is low
        out_ready = 1'b0;
        sb_q.push_back(mk(32'h3F800000, 1, 1'b0, 1'b0));
        start_run(1, 1'b0);
        feed(32'h3F800000, 0);
        @(negedge clk);
        check("len1_latency_valid", 32'(out_valid), 32'd1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_sum",   out_sum,        32'h3F800000);
            check("bp_count", 32'(out_count), 32'd1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_done();

        // in_valid gaps in FETCH stall without losing data
        run(3, 1'b0, pack4(32'h3F800000, 32'h40000000, 32'h3F000000, 0), 3,
            mk(32'h40600000, 3, 1'b0, 1'b0));

        // Reset during ADD abandons the reduction
        start_run(4, 1'b0);
        feed(32'h3F800000, 0);
        feed(32'h40000000, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_busy",      32'(busy),      32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_acc",       out_sum,        32'd0);
        check("midrst_in_ready",  32'(in_ready),  32'd0);
        run(1, 1'b0, pack4(32'h40000000, 0, 0, 0), 0,
            mk(32'h40000000, 1, 1'b0, 1'b0));

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/fp_accum_seq.md
Name: fp_accum_seq

Overview:
- Sequential float32 accumulator. Sits directly upstream of the team's combinational add_sub stage and drives one instance of it.
- Accepts a stream of `len` IEEE-754 single operands over a valid/ready handshake. Feeds (accumulator, operand) pairs into add_sub one pair at a time and registers each result back into the accumulator.
- Presents the final sum, element count and sticky overflow/underflow flags on an output valid/ready handshake.
- Lets the ALU reduce vectors without an external sequencer.

Parameters:
CNT_W, 16, width of the length and element counters (max vector length 2^CNT_W-1)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
start  in  1  begin a new reduction; sampled only in IDLE
len  in  CNT_W  number of elements; captured on start
sub_mode  in  1  0: sum = x0+x1+...; 1: sum = x0-x1-x2-...; captured on start
in_valid  in  1  upstream operand valid
in_data  in  32  float32 operand
in_ready  out  1  block accepts in_data this cycle
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_sum  out  32  accumulated float32 result
out_count  out  CNT_W  elements consumed
overflag  out  1  sticky: any add_sub step flagged overflow
underflag  out  1  sticky: any add_sub step flagged underflow
busy  out  1  high in every state except IDLE

Behaviour:
- Reset, synchronous: state=IDLE; acc, op_reg, cnt, len_reg, flags and all outputs cleared to 0; in_ready=0; out_valid=0. Reset in any state, including mid-ADD or while DONE is stalled, abandons the reduction. No partial result is emitted.
- States:
  - IDLE:
    - in_ready=0.
    - start=1 latches len_reg, sub_mode_reg; clears acc, cnt, flags.
    - len=0 -> DONE with out_sum=0x00000000 and out_count=0; otherwise -> FIRST.
  - FIRST:
    - in_ready=1.
    - On in_valid&in_ready: acc<=in_data unchanged (sign not inverted even when sub_mode=1), cnt<=1.
    - -> DONE if len_reg==1, else FETCH.
  - FETCH:
    - in_ready=1.
    - On handshake: op_reg<=in_data, -> ADD.
    - No handshake: remain.
  - ADD:
    - in_ready=0.
    - add_sub driven with A=acc, B=op_reg, add_or_sub=sub_mode_reg.
    - acc<=result; overflag|=step overflow; underflag|=step underflow; cnt<=cnt+1.
    - -> DONE if cnt+1==len_reg, else FETCH.
  - DONE:
    - out_valid=1; out_sum=acc; out_count=cnt; flags held.
    - Outputs stable while out_ready=0.
    - On out_ready: -> IDLE, out_valid<=0.
- Throughput: 2 cycles per element after the first.
- Latency: last input handshake to out_valid is 2 cycles when len≥2, and 1 cycle when len==1.
- start outside IDLE is ignored. Input data offered in IDLE or DONE is not accepted (in_ready=0).
- Counters are CNT_W wide with no wrap: cnt never exceeds len_reg.
- add_sub is purely combinational. Its inputs come only from registers (acc, op_reg), so no input-to-output combinational path exists.
- Flags are sticky for one reduction and cleared on the next accepted start.
- Same-cycle start with out_ready in DONE: start is ignored. The block returns to IDLE first.

Optional Feature:
- Macro: FP_ACCUM_EARLY_STOP_EN.
- Defined: an ADD step raising overflow sets overflag and moves to DONE immediately. out_count is the number of elements consumed so far; remaining upstream elements are not consumed.
- Undefined: accumulation always consumes exactly len elements regardless of flags.

Decomposition:
- Shared package fp_pkg:
  - FP_W=32, EXP_W=8, FRAC_W=23.
  - Constants FP_POS_ZERO=32'h00000000, FP_POS_INF=32'h7F800000.
  - Accumulator state enum (IDLE, FIRST, FETCH, ADD, DONE).
- Sub-module: one instance of the existing add_sub as the datapath.
- FSM and registers live in fp_accum_seq itself; no further split.

Test Plan:
- len=3, sub_mode=0, inputs 0x3F800000, 0x40000000, 0x3F000000 -> out_sum=0x40600000 (3.5), out_count=3, flags 0.
- len=3, sub_mode=1, inputs 0x40A00000, 0x3F800000, 0x3FC00000 -> out_sum=0x40200000 (2.5), out_count=3.
- len=2, inputs 0x7F7FFFFF, 0x7F7FFFFF -> overflag=1 at DONE. With FP_ACCUM_EARLY_STOP_EN and len=4: out_count=2 and only 2 input handshakes occur.
- start with len=0 -> out_valid the cycle after start, out_sum=0x00000000, out_count=0, no input handshake.
- Backpressure: len=1 input 0x3F800000, out_ready held low 5 cycles -> out_sum/out_count/out_valid stable all 5 cycles. in_valid gaps in FETCH stall without losing data.
- Reset asserted during ADD of a len=4 run -> next cycle state IDLE, busy=0, out_valid=0, acc=0. A following len=1 run with 0x40000000 yields out_sum=0x40000000.
